// File: rtl/wb_pkg.sv
// Shared widths and the writeback request payload for the WB write arbiter.
package wb_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bus bundle between the pipeline, the long-latency unit, decode and the arbiter.
//  master: drives pipe_*, lu_valid/dst/data, regS/regT, hlt; sees results.
//  slave : the arbiter; drives lu_ready, we, dst_reg_WB, dst_reg_data_WB,
//          pend_S, pend_T, drained.
interface wb_write_arbiter_if;
  import wb_pkg::*;

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_dst;
  logic [DATA_W-1:0] pipe_data;
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_dst;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              we;
  logic [ADDR_W-1:0] dst_reg_WB;
  logic [DATA_W-1:0] dst_reg_data_WB;
  logic [ADDR_W-1:0] regS;
  logic [ADDR_W-1:0] regT;
  logic              pend_S;
  logic              pend_T;
  logic              hlt;
  logic              drained;

  modport master (
    output pipe_we, pipe_dst, pipe_data, lu_valid, lu_dst, lu_data,
           regS, regT, hlt,
    input  lu_ready, we, dst_reg_WB, dst_reg_data_WB, pend_S, pend_T, drained
  );

  modport slave (
    input  pipe_we, pipe_dst, pipe_data, lu_valid, lu_dst, lu_data,
           regS, regT, hlt,
    output lu_ready, we, dst_reg_WB, dst_reg_data_WB, pend_S, pend_T, drained
  );

endinterface

// File: rtl/wb_queue.sv
// Synchronous FIFO of long-latency writeback results with per-entry valid
// bits and two CAM lookups used for hazard reporting.
//  clk, rst_n            clock, synchronous active-low reset
//  push_i, push_req_i    enqueue request (ignored when full)
//  pop_i, head_o         dequeue request (ignored when empty) and head entry
//  empty_o, full_o       occupancy flags from the registered count
//  reg_s_i/reg_t_i       lookup addresses
//  match_s_o/match_t_o   address matches some valid entry
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  wb_req_t           push_req_i,
  input  logic              pop_i,
  output wb_req_t           head_o,
  output logic              empty_o,
  output logic              full_o,
  input  logic [ADDR_W-1:0] reg_s_i,
  input  logic [ADDR_W-1:0] reg_t_i,
  output logic              match_s_o,
  output logic              match_t_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_req_t            mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;
  logic [DEPTH-1:0]   hit_s, hit_t;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Next occupancy and valid bits; push and pop never target the same slot.
  always_comb begin
    valid_d = valid_q;
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_pop)  valid_d[rd_ptr_q] = 1'b0;
    if (do_push) valid_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_req_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Destination CAM over valid entries only.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cam
    assign hit_s[g] = valid_q[g] && (mem_q[g].dst == reg_s_i);
    assign hit_t[g] = valid_q[g] && (mem_q[g].dst == reg_t_i);
  end

  assign match_s_o = |hit_s;
  assign match_t_o = |hit_t;

endmodule

// File: rtl/wb_write_arbiter.sv
// Single writer for the register-file write port. In-order pipeline
// writebacks take priority; long-latency results wait in wb_queue and are
// written in arrival order whenever the pipeline is not writing.
//  clk, rst_n  clock, synchronous active-low reset
//  bus         wb_write_arbiter_if slave: pipe/lu requests in, RF write port,
//              pend_S/pend_T hazard flags and drained status out
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  wb_write_arbiter_if.slave       bus
);

  logic              q_empty, q_full;
  logic              match_s, match_t;
  logic              ready_c, push_c, pipe_go_c, pop_c;
  wb_req_t           lu_req_c, head_c;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              unused_hlt;

  // Halt only tells the core to stop issuing; the queue keeps draining.
  assign unused_hlt = bus.hlt;

  // Ready comes from the registered count only; no credit for a same-cycle pop.
  assign ready_c   = rst_n && !q_full;
  // R0 results complete the handshake but are never stored.
  assign push_c    = bus.lu_valid && ready_c && (bus.lu_dst != '0);
  assign pipe_go_c = bus.pipe_we && (bus.pipe_dst != '0);
  assign pop_c     = !pipe_go_c && !q_empty;

  assign lu_req_c.dst  = bus.lu_dst;
  assign lu_req_c.data = bus.lu_data;

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_c),
    .push_req_i (lu_req_c),
    .pop_i      (pop_c),
    .head_o     (head_c),
    .empty_o    (q_empty),
    .full_o     (q_full),
    .reg_s_i    (bus.regS),
    .reg_t_i    (bus.regT),
    .match_s_o  (match_s),
    .match_t_o  (match_t)
  );

  // Write-port mux: pipeline first, then queue head; idle holds addr/data.
  always_comb begin
    we_d   = 1'b0;
    dst_d  = dst_q;
    data_d = data_q;
    if (pipe_go_c) begin
      we_d   = 1'b1;
      dst_d  = bus.pipe_dst;
      data_d = bus.pipe_data;
    end else if (pop_c) begin
      we_d   = 1'b1;
      dst_d  = head_c.dst;
      data_d = head_c.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      dst_q  <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      dst_q  <= dst_d;
      data_q <= data_d;
    end
  end

  assign bus.lu_ready        = ready_c;
  assign bus.we              = we_q;
  assign bus.dst_reg_WB      = dst_q;
  assign bus.dst_reg_data_WB = data_q;

  // A head being popped is still in the queue this cycle, so it stays pending.
  assign bus.pend_S = (bus.regS != '0) &&
                      (match_s || (push_c && (bus.lu_dst == bus.regS)));
  assign bus.pend_T = (bus.regT != '0) &&
                      (match_t || (push_c && (bus.lu_dst == bus.regT)));

  assign bus.drained = q_empty && !we_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: queue-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_wb_write_arbiter;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_write_arbiter_if bus ();

  wb_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a plain FIFO plus the last RF write.
  wb_req_t           mq[$];
  wb_req_t           m_head;
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_dst = '0;
  logic [DATA_W-1:0] m_data = '0;
  bit                m_valid = 1'b0;
  bit                m_acc, m_go;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return rst_n && (mq.size() < DEPTH);
  endfunction

  function automatic bit exp_pend(input logic [ADDR_W-1:0] r);
    if (r == '0) return 1'b0;
    foreach (mq[i]) if (mq[i].dst == r) return 1'b1;
    return bus.lu_valid && exp_ready() && (bus.lu_dst == r);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_we    = 1'b0;
      m_dst   = '0;
      m_data  = '0;
      m_valid = 1'b1;
    end else begin
      m_acc = bus.lu_valid && (mq.size() < DEPTH);
      m_go  = bus.pipe_we && (bus.pipe_dst != '0);
      if (m_go) begin
        m_we = 1'b1; m_dst = bus.pipe_dst; m_data = bus.pipe_data;
      end else if (mq.size() > 0) begin
        m_head = mq.pop_front();
        m_we = 1'b1; m_dst = m_head.dst; m_data = m_head.data;
      end else begin
        m_we = 1'b0;
      end
      if (m_acc && (bus.lu_dst != '0)) mq.push_back('{dst: bus.lu_dst, data: bus.lu_data});
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_we",      32'(bus.we),              32'(m_we));
      chk("m_dst",     32'(bus.dst_reg_WB),      32'(m_dst));
      chk("m_data",    32'(bus.dst_reg_data_WB), 32'(m_data));
      chk("m_ready",   32'(bus.lu_ready),        32'(exp_ready()));
      chk("m_pend_S",  32'(bus.pend_S),          32'(exp_pend(bus.regS)));
      chk("m_pend_T",  32'(bus.pend_T),          32'(exp_pend(bus.regT)));
      chk("m_drained", 32'(bus.drained),         32'((mq.size() == 0) && !m_we));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic v, input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] x);
    bus.pipe_we = v; bus.pipe_dst = d; bus.pipe_data = x;
  endtask

  task automatic lu(input logic v, input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] x);
    bus.lu_valid = v; bus.lu_dst = d; bus.lu_data = x;
  endtask

  initial begin
    rst_n = 1'b0;
    pipe(1'b0, '0, '0);
    lu(1'b0, '0, '0);
    bus.regS = '0; bus.regT = '0; bus.hlt = 1'b0;
    step(); step();
    chk("rst_we",      32'(bus.we), 0);
    chk("rst_dst",     32'(bus.dst_reg_WB), 0);
    chk("rst_data",    bus.dst_reg_data_WB, 0);
    chk("rst_ready",   32'(bus.lu_ready), 0);
    chk("rst_drained", 32'(bus.drained), 1);
    rst_n = 1'b1; #1;
    chk("ready_after_rst", 32'(bus.lu_ready), 1);

    // Plain pipeline write lands the next cycle.
    pipe(1'b1, 5'd3, 32'hDEADBEEF);
    step();
    pipe(1'b0, '0, '0);
    chk("t1_we",    32'(bus.we), 1);
    chk("t1_dst",   32'(bus.dst_reg_WB), 3);
    chk("t1_data",  bus.dst_reg_data_WB, 32'hDEADBEEF);
    chk("t1_ready", 32'(bus.lu_ready), 1);
    step();
    chk("t1_idle_we",  32'(bus.we), 0);
    chk("t1_hold_dst", 32'(bus.dst_reg_WB), 3);
    chk("t1_hold_data", bus.dst_reg_data_WB, 32'hDEADBEEF);

    // R0 writes from both sources are dropped.
    pipe(1'b1, 5'd0, 32'h1111);
    lu(1'b1, 5'd0, 32'h2222);
    #1 chk("t2_ready", 32'(bus.lu_ready), 1);
    step();
    chk("t2_we",      32'(bus.we), 0);
    chk("t2_ready2",  32'(bus.lu_ready), 1);
    chk("t2_drained", 32'(bus.drained), 1);
    step();
    chk("t2_we2", 32'(bus.we), 0);
    pipe(1'b0, '0, '0);
    lu(1'b0, '0, '0);

    // lu result waits behind three pipeline writes, pending throughout.
    bus.regS = 5'd7; bus.regT = 5'd4;
    pipe(1'b1, 5'd4, 32'h40);
    lu(1'b1, 5'd7, 32'h77);
    #1 chk("t3_pend_push", 32'(bus.pend_S), 1);
    step();
    lu(1'b0, '0, '0);
    pipe(1'b1, 5'd4, 32'h41);
    #1 chk("t3_pend_q1", 32'(bus.pend_S), 1);
    chk("t3_dst1", 32'(bus.dst_reg_WB), 4);
    step();
    pipe(1'b1, 5'd4, 32'h42);
    chk("t3_data2", bus.dst_reg_data_WB, 32'h41);
    step();
    pipe(1'b0, '0, '0);
    #1 chk("t3_pend_popping", 32'(bus.pend_S), 1);
    chk("t3_data3", bus.dst_reg_data_WB, 32'h42);
    step();
    chk("t3_lu_we",   32'(bus.we), 1);
    chk("t3_lu_dst",  32'(bus.dst_reg_WB), 7);
    chk("t3_lu_data", bus.dst_reg_data_WB, 32'h77);
    chk("t3_pend_done", 32'(bus.pend_S), 0);
    chk("t3_not_drained", 32'(bus.drained), 0);
    step();
    chk("t3_drained", 32'(bus.drained), 1);

    // Fill the queue behind a busy pipeline, then drain with a blocked push.
    bus.regS = '0; bus.regT = 5'd10;
    pipe(1'b1, 5'd5, 32'h50);
    for (int k = 0; k < 4; k++) begin
      lu(1'b1, ADDR_W'(8 + k), DATA_W'(32'h800 + k));
      step();
    end
    lu(1'b1, 5'd12, 32'h80C);
    #1 chk("t4_full_ready", 32'(bus.lu_ready), 0);
    chk("t4_pend_T", 32'(bus.pend_T), 1);
    step();
    chk("t4_still_full", 32'(bus.lu_ready), 0);
    pipe(1'b0, '0, '0);
    step();
    chk("t5_pop_dst",  32'(bus.dst_reg_WB), 8);
    chk("t5_pop_data", bus.dst_reg_data_WB, 32'h800);
    chk("t5_ready",    32'(bus.lu_ready), 1);
    step();
    lu(1'b0, '0, '0);
    chk("t5_dst9",  32'(bus.dst_reg_WB), 9);
    chk("t5_ready2", 32'(bus.lu_ready), 1);
    step(); chk("t5_dst10", 32'(bus.dst_reg_WB), 10);
    step(); chk("t5_dst11", 32'(bus.dst_reg_WB), 11);
    step();
    chk("t5_dst12",  32'(bus.dst_reg_WB), 12);
    chk("t5_data12", bus.dst_reg_data_WB, 32'h80C);
    step();
    chk("t5_we_end",   32'(bus.we), 0);
    chk("t5_drained",  32'(bus.drained), 1);

    // Halt with two queued results: drained only after the second write.
    bus.hlt = 1'b1; bus.regT = '0;
    pipe(1'b1, 5'd5, 32'h55);
    lu(1'b1, 5'd13, 32'hD);
    step();
    lu(1'b1, 5'd14, 32'hE);
    step();
    lu(1'b0, '0, '0);
    pipe(1'b0, '0, '0);
    step();
    chk("t6_dst13",  32'(bus.dst_reg_WB), 13);
    chk("t6_drn_a",  32'(bus.drained), 0);
    step();
    chk("t6_dst14",  32'(bus.dst_reg_WB), 14);
    chk("t6_drn_b",  32'(bus.drained), 0);
    step();
    chk("t6_drn_c",  32'(bus.drained), 1);

    // Reset with three queued results discards them.
    pipe(1'b1, 5'd6, 32'h66);
    for (int k = 0; k < 3; k++) begin
      lu(1'b1, ADDR_W'(15 + k), DATA_W'(32'hF0 + k));
      step();
    end
    lu(1'b0, '0, '0);
    bus.regS = 5'd15; bus.regT = 5'd17;
    #1 chk("t6_pend_S_q", 32'(bus.pend_S), 1);
    chk("t6_pend_T_q", 32'(bus.pend_T), 1);
    rst_n = 1'b0;
    step();
    chk("t6_rst_we",     32'(bus.we), 0);
    chk("t6_rst_drn",    32'(bus.drained), 1);
    chk("t6_rst_pend_S", 32'(bus.pend_S), 0);
    chk("t6_rst_pend_T", 32'(bus.pend_T), 0);
    rst_n = 1'b1;
    pipe(1'b0, '0, '0);
    bus.hlt = 1'b0;
    step();
    chk("t6_post_we",  32'(bus.we), 0);
    chk("t6_post_drn", 32'(bus.drained), 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
